// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage with stall and flush hooks from
// the hazard unit. Define PIPE_STAGE_SKID_EN to build the 2-entry skid
// variant with a registered in_ready. Otherwise the stage holds one entry
// and in_ready is computed combinationally.
module pipe_stage_hs #(
    parameter int unsigned           DATA_W     = 96,
    parameter logic [DATA_W-1:0]     BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              rdy_q;
    logic [DATA_W-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q;
`endif
    logic              in_xfer;
    logic              out_xfer;

    // Presentation side: the head entry is offered only when not stalled
    assign occupancy = state;
    assign out_valid = (state != EMPTY) && !stall;
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;

`ifdef PIPE_STAGE_SKID_EN
    // rdy_q tracks "room for another entry"; stall only masks it
    assign in_ready = rdy_q && !stall;
`else
    // rdy_q is low only from reset until the first edge after release
    assign in_ready = rdy_q && !stall && ((state == EMPTY) || out_ready);
`endif

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Occupancy FSM with entry storage and the registered ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            rdy_q  <= 1'b0;
            main_q <= BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= BUBBLE_VAL;
`endif
        end else if (flush) begin
            // Squash everything held plus any same-cycle input
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else if (stall) begin
            // Storage frozen; ready flag just mirrors the held occupancy
            rdy_q <= (state != FULL);
        end else begin
            case (state)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (in_xfer) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    rdy_q <= 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        skid_q <= in_data;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
`else
                    // An input transfer here always coincides with an output
                    if (out_xfer) begin
                        if (in_xfer) begin
                            main_q <= in_data;
                        end else begin
                            state <= EMPTY;
                        end
                    end
`endif
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                    end else begin
                        rdy_q <= 1'b0;
                    end
`else
                    state <= EMPTY;
                    rdy_q <= 1'b1;
`endif
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed scenarios plus random
// traffic, all compared against a queue-based model of the stage.
module tb_pipe_stage_hs;

    localparam int unsigned DW = 96;
    localparam logic [DW-1:0] BUB = '0;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    // Model: entries in arrival order; alive goes high at the first edge after reset
    logic [DW-1:0] q[$];
    bit            alive;

    pipe_stage_hs #(.DATA_W(DW), .BUBBLE_VAL(BUB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update the model
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic st, input logic fl, output bit acc);
        logic exp_ir, exp_ov;
        bit   out_x;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        #1;
        if (SKID) exp_ir = alive && !st && (q.size() < 2);
        else      exp_ir = alive && !st && (q.size() == 0 || ordy);
        exp_ov = (q.size() != 0) && !st;
        chk("in_ready", DW'(in_ready), DW'(exp_ir));
        chk("out_valid", DW'(out_valid), DW'(exp_ov));
        chk("occupancy", DW'(occupancy), DW'(q.size()));
        if (exp_ov)            chk("out_data", out_data, q[0]);
        else if (q.size() == 0) chk("out_data_bubble", out_data, BUB);
        acc   = v && exp_ir && !fl;
        out_x = exp_ov && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (v && exp_ir) q.push_back(d);
        end
        alive = 1'b1;
        #1;
    endtask

    initial begin
        bit            acc;
        logic [DW-1:0] pend;
        bit            have;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0;
        flush = 1'b0; out_ready = 1'b0; alive = 1'b0;
        #2;
        chk("rst_occupancy", DW'(occupancy), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data", out_data, BUB);
        @(posedge clk); #1;
        reset = 1'b0;

        // Straight stream 1..8 with downstream always ready
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Skid build: A accepted, downstream blocks while B and C are offered
        cyc(1'b1, DW'(32'hA), 1'b1, 1'b0, 1'b0, acc);
        cyc(1'b1, DW'(32'hB), 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, DW'(32'hC), 1'b0, 1'b0, 1'b0, acc);
        have = 1'b1; pend = DW'(32'hC);
        for (int i = 0; i < 6; i++) begin
            cyc(have, pend, 1'b1, 1'b0, 1'b0, acc);
            if (acc) have = 1'b0;
        end

        // Stall for 3 cycles while 0x55 is held
        cyc(1'b1, DW'(32'h55), 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h66), 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Fill up, then flush together with an incoming entry
        cyc(1'b1, DW'(32'h71), 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, DW'(32'h72), 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, DW'(32'h73), 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Flush wins over a simultaneous stall
        cyc(1'b1, DW'(32'h81), 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Reset mid-stream with the stage filled
        cyc(1'b1, DW'(32'h91), 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, DW'(32'h92), 1'b0, 1'b0, 1'b0, acc);
        reset = 1'b1;
        #1;
        chk("mid_rst_occupancy", DW'(occupancy), DW'(0));
        chk("mid_rst_in_ready", DW'(in_ready), DW'(0));
        chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_out_data", out_data, BUB);
        q.delete();
        alive = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Random traffic; an offered entry stays put until it is taken
        have = 1'b0; pend = '0;
        for (int i = 0; i < 400; i++) begin
            logic v, ordy, st, fl;
            if (!have && ($urandom_range(0, 3) != 0)) begin
                have = 1'b1;
                pend = {$urandom(), $urandom(), $urandom()};
            end
            v    = have;
            ordy = ($urandom_range(0, 2) != 0);
            st   = ($urandom_range(0, 9) == 0);
            fl   = ($urandom_range(0, 24) == 0);
            cyc(v, pend, ordy, st, fl, acc);
            if (acc || (fl && v)) have = 1'b0;
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
